// File: rtl/mac_pkg.sv
// mac_pkg: shared types and arithmetic helpers for the mac_array engine.
// Build option MAC_SAT_EN selects saturating accumulation.
package mac_pkg;

    // Sideband tags that travel alongside the multiplier pipe.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } mac_tag_t;

    // Saturating-add result: clamp indicator plus the clamped sum.
    typedef struct packed {
        logic               sat;
        logic signed [63:0] sum;
    } sat_res_t;

    // Width of a full signed product.
    function automatic int MAC_WP(input int wx, input int wk);
        return wx + wk;
    endfunction

    // Adds two sign-extended operands and clamps the result to a wy-bit
    // signed range.  wy must be at most 63.
    function automatic sat_res_t sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 wy
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_res_t           r;
        s     = a + b;
        hi    = (64'sd1 <<< (wy - 1)) - 64'sd1;
        lo    = -hi - 64'sd1;
        r.sat = 1'b0;
        r.sum = s;
        if (s > hi) begin
            r.sat = 1'b1;
            r.sum = hi;
        end else if (s < lo) begin
            r.sat = 1'b1;
            r.sum = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_array_lane.sv
// mac_lane: one lane of multiplier pipe, accumulator and saturation flag.
// Build option MAC_SAT_EN adds clamping and the sticky per-lane flag.
module mac_lane
    import mac_pkg::*;
#(
    parameter int WX = 8,
    parameter int WK = 8,
    parameter int WY = 32,
    parameter int LM = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic signed [WX-1:0] x,
    input  logic signed [WK-1:0] k,
    input  mac_tag_t             tag,
    output logic signed [WY-1:0] y,
    output logic                 sat
);

    localparam int WP = MAC_WP(WX, WK);

    logic signed [WP-1:0] pp [LM];
    logic signed [WY-1:0] pe;
    logic signed [WY-1:0] base;
    logic signed [WY-1:0] sum;
    logic signed [WY-1:0] acc;
    logic                 take;
    logic                 emit;

    assign take = en && tag.valid;
    assign emit = take && tag.last;

    // Multiplier pipe: product enters stage 0 and shifts on every advance.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int j = 0; j < LM; j++) pp[j] <= '0;
        end else if (en) begin
            pp[0] <= WP'(x) * WP'(k);
            for (int j = 1; j < LM; j++) pp[j] <= pp[j-1];
        end
    end

    assign pe   = WY'(pp[LM-1]);
    assign base = tag.first ? '0 : acc;

`ifdef MAC_SAT_EN
    sat_res_t r;
    logic     flag;
    logic     flag_nx;
    logic     sum_unused;

    assign r          = sat_add(64'(pe), 64'(base), WY);
    assign sum        = r.sum[WY-1:0];
    assign sum_unused = ^r.sum[63:WY];
    assign flag_nx    = (flag && !tag.first) || r.sat;

    // Sticky clamp flag: cleared by a first beat, set by any clamp.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            flag <= 1'b0;
        end else if (take) begin
            flag <= flag_nx;
        end
    end

    // Result flag is captured together with the result value.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sat <= 1'b0;
        end else if (emit) begin
            sat <= flag_nx;
        end
    end
`else
    assign sum = pe + base;
    assign sat = 1'b0;
`endif

    // Accumulator: restarts on first, otherwise adds onto the running sum.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc <= '0;
        end else if (take) begin
            acc <= sum;
        end
    end

    // Result register: loads the same-cycle sum on a last beat.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            y <= '0;
        end else if (emit) begin
            y <= sum;
        end
    end

endmodule

// File: rtl/mac_array.sv
// mac_array: C-lane signed multiply-accumulate with valid/ready framing.
// Build option MAC_SAT_EN enables saturating accumulation and m_sat.
module mac_array
    import mac_pkg::*;
#(
    parameter int C  = 4,
    parameter int WX = 8,
    parameter int WK = 8,
    parameter int WY = 32,
    parameter int LM = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic            s_first,
    input  logic            s_last,
    input  logic [C*WX-1:0] s_x,
    input  logic [C*WK-1:0] s_k,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [C*WY-1:0] m_y,
    output logic [C-1:0]    m_sat
);

    logic     en;
    mac_tag_t tin;
    mac_tag_t tg [LM];

    // The whole pipe advances only when the output slot is free.
    assign en      = !m_valid || m_ready;
    assign s_ready = en;

    assign tin.valid = s_valid;
    assign tin.first = s_first;
    assign tin.last  = s_last;

    // Shared tag pipe, aligned with every lane's multiplier pipe.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int j = 0; j < LM; j++) tg[j] <= '0;
        end else if (en) begin
            tg[0] <= tin;
            for (int j = 1; j < LM; j++) tg[j] <= tg[j-1];
        end
    end

    // Output valid: set by a completing frame, dropped once consumed.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            m_valid <= 1'b0;
        end else if (en) begin
            m_valid <= tg[LM-1].valid && tg[LM-1].last;
        end
    end

    for (genvar i = 0; i < C; i++) begin : g_lane
        mac_lane #(
            .WX(WX),
            .WK(WK),
            .WY(WY),
            .LM(LM)
        ) u_lane (
            .clk (clk),
            .rstn(rstn),
            .en  (en),
            .x   (s_x[i*WX +: WX]),
            .k   (s_k[i*WK +: WK]),
            .tag (tg[LM-1]),
            .y   (m_y[i*WY +: WY]),
            .sat (m_sat[i])
        );
    end

endmodule
